// File: rtl/pulse_train_scheduler.sv
// ---------------------------------------------------------------------------
// pulse_train_scheduler
//
// Pulse-train timing controller. A burst of NUM_OF_IMP impulses is generated
// after SIGN_START_GEN. Each impulse holds GATE high for T_IMPULSE time
// units and then low for the rest of its period. The period is read from a
// writable table, either always entry 0 or cycling through the first
// TBL_LEN entries (vobulation).
//
// SIGN_START_CALC marks the first GATE cycle of every impulse, and
// SIGN_STOP_CALC marks the first cycle after it. At every impulse boundary
// OUT_REG_READY is sampled; while it is low the controller waits with its
// timers frozen. ABORT cancels a burst. All outputs are registered.
//
// Optional feature macro: SCHED_CONTINUOUS_EN
//   defined   : NUM_OF_IMP = 0 runs impulses until ABORT/RESET.
//   undefined : NUM_OF_IMP = 0 is rejected with CFG_ERR.
//
// Ports
//   CLK, RESET        clock, synchronous active-high reset
//   TBL_WE/ADDR/DATA  period-table write (only while idle)
//   TBL_LEN           number of active table entries (1..DEPTH)
//   T_IMPULSE         impulse length in time units
//   NUM_OF_IMP        impulses per burst
//   VOBULATION        1 = cycle through table, 0 = entry 0 only
//   SIGN_START_GEN    burst start request
//   ABORT             burst cancel
//   OUT_REG_READY     downstream ready, sampled at impulse boundaries
//   GATE              high during an impulse
//   SIGN_START_CALC   first GATE cycle strobe
//   SIGN_STOP_CALC    first cycle after GATE strobe
//   IMP_IDX, PER_IDX  current impulse number / table entry in use
//   BUSY              burst in progress
//   DONE              last cycle of a normally completed burst
//   CFG_ERR           last start request was rejected for bad config
// ---------------------------------------------------------------------------
module pulse_train_scheduler #(
  parameter int DEPTH          = 16,
  parameter int IMP_W          = 10,
  parameter int PER_W          = 13,
  parameter int CNT_W          = 5,
  parameter int TICKS_PER_UNIT = 100,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             TBL_WE,
  input  logic [AW-1:0]    TBL_ADDR,
  input  logic [PER_W-1:0] TBL_DATA,
  input  logic [AW:0]      TBL_LEN,
  input  logic [IMP_W-1:0] T_IMPULSE,
  input  logic [CNT_W-1:0] NUM_OF_IMP,
  input  logic             VOBULATION,
  input  logic             SIGN_START_GEN,
  input  logic             ABORT,
  input  logic             OUT_REG_READY,
  output logic             GATE,
  output logic             SIGN_START_CALC,
  output logic             SIGN_STOP_CALC,
  output logic [CNT_W-1:0] IMP_IDX,
  output logic [AW-1:0]    PER_IDX,
  output logic             BUSY,
  output logic             DONE,
  output logic             CFG_ERR
);

  localparam int LEN_W = AW + 1;
  localparam int PRE_W = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICKS_PER_UNIT - 1);
  localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_RDY = 2'd1,
    S_PULSE    = 2'd2,
    S_GAP      = 2'd3
  } state_t;

  state_t             r_state;
  logic [PER_W-1:0]   r_tbl [DEPTH];
  logic [IMP_W-1:0]   r_timp;
  logic [CNT_W-1:0]   r_num;
  logic               r_vob;
  logic [LEN_W-1:0]   r_len;
  logic [PRE_W-1:0]   r_pre;
  logic [PER_W-1:0]   r_unit;
  logic [CNT_W-1:0]   r_imp_idx;
  logic [AW-1:0]      r_per_idx;
  logic               r_gate;
  logic               r_start_calc;
  logic               r_stop_calc;
  logic               r_busy;
  logic               r_done;
  logic               r_cfg_err;

  state_t             w_state_nxt;
  logic [PRE_W-1:0]   w_pre_nxt;
  logic [PER_W-1:0]   w_unit_nxt;
  logic [CNT_W-1:0]   w_imp_nxt;
  logic [AW-1:0]      w_per_nxt;
  logic [PER_W-1:0]   w_timp_ext;
  logic               w_used;
  logic               w_per_bad;
  logic               w_len_bad;
  logic               w_num_bad;
  logic               w_cfg_ok;
  logic               w_start_req;
  logic               w_accept;
  logic               w_reject;
  logic [PER_W-1:0]   w_per_cur;
  logic               w_pre_wrap;
  logic               w_pulse_last;
  logic               w_gap_last;
  logic               w_last_imp;
  logic [AW-1:0]      w_per_adv;
  logic               w_done_nxt;

  // Start-time configuration check against the live inputs and table.
  always_comb begin
    w_timp_ext = PER_W'(T_IMPULSE);
    w_used     = 1'b0;
    w_per_bad  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_used    = (i == 0) || (VOBULATION && (LEN_W'(i) < TBL_LEN));
      w_per_bad = w_per_bad | (w_used & (w_timp_ext >= r_tbl[i]));
    end
    w_len_bad = (TBL_LEN == '0) || (TBL_LEN > DEPTH_LEN);
`ifdef SCHED_CONTINUOUS_EN
    w_num_bad = 1'b0;
`else
    w_num_bad = (NUM_OF_IMP == '0);
`endif
    w_cfg_ok    = ~(w_len_bad | w_num_bad | w_per_bad | (T_IMPULSE == '0));
    // ABORT outranks a start request arriving in the same cycle.
    w_start_req = SIGN_START_GEN & ~ABORT & (r_state == S_IDLE);
    w_accept    = w_start_req & w_cfg_ok;
    w_reject    = w_start_req & ~w_cfg_ok;
  end

  // Timer end-of-phase decodes and the next table index.
  always_comb begin
    w_per_cur    = r_tbl[r_per_idx];
    w_pre_wrap   = (r_pre == PRE_LAST);
    w_pulse_last = (r_unit == (PER_W'(r_timp) - PER_W'(1)));
    w_gap_last   = (r_unit == (w_per_cur - PER_W'(1)));
`ifdef SCHED_CONTINUOUS_EN
    // A latched count of zero means the burst never ends on its own.
    w_last_imp   = (r_num != '0) && (r_imp_idx == (r_num - CNT_W'(1)));
`else
    w_last_imp   = (r_imp_idx == (r_num - CNT_W'(1)));
`endif
    if (r_vob) begin
      w_per_adv = (LEN_W'(r_per_idx) == (r_len - LEN_W'(1))) ? '0 : (r_per_idx + AW'(1));
    end else begin
      w_per_adv = '0;
    end
  end

  // Next-state and next-counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_pre_nxt   = r_pre;
    w_unit_nxt  = r_unit;
    w_imp_nxt   = r_imp_idx;
    w_per_nxt   = r_per_idx;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_pre_nxt   = '0;
          w_unit_nxt  = '0;
          w_imp_nxt   = '0;
          w_per_nxt   = '0;
          w_state_nxt = OUT_REG_READY ? S_PULSE : S_WAIT_RDY;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_RDY: begin
        // Timers were cleared on entry and stay frozen here.
        if (ABORT) begin
          w_state_nxt = S_IDLE;
        end else if (OUT_REG_READY) begin
          w_state_nxt = S_PULSE;
        end else begin
          w_state_nxt = S_WAIT_RDY;
        end
      end
      S_PULSE: begin
        if (ABORT) begin
          w_state_nxt = S_IDLE;
        end else if (w_pre_wrap) begin
          // The unit counter runs on into the gap, so the gap ends at period-1.
          w_pre_nxt   = '0;
          w_unit_nxt  = r_unit + PER_W'(1);
          w_state_nxt = w_pulse_last ? S_GAP : S_PULSE;
        end else begin
          w_pre_nxt   = r_pre + PRE_W'(1);
        end
      end
      S_GAP: begin
        if (ABORT) begin
          w_state_nxt = S_IDLE;
        end else if (w_pre_wrap && w_gap_last) begin
          w_pre_nxt  = '0;
          w_unit_nxt = '0;
          if (w_last_imp) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_imp_nxt   = r_imp_idx + CNT_W'(1);
            w_per_nxt   = w_per_adv;
            w_state_nxt = OUT_REG_READY ? S_PULSE : S_WAIT_RDY;
          end
        end else if (w_pre_wrap) begin
          w_pre_nxt  = '0;
          w_unit_nxt = r_unit + PER_W'(1);
        end else begin
          w_pre_nxt  = r_pre + PRE_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // DONE is registered, so it is raised when the coming cycle is the last gap cycle.
    w_done_nxt = (w_state_nxt == S_GAP) && (w_pre_nxt == PRE_LAST) &&
                 (w_unit_nxt == (w_per_cur - PER_W'(1))) && w_last_imp;
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_pre        <= '0;
      r_unit       <= '0;
      r_imp_idx    <= '0;
      r_per_idx    <= '0;
      r_gate       <= 1'b0;
      r_start_calc <= 1'b0;
      r_stop_calc  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pre        <= w_pre_nxt;
      r_unit       <= w_unit_nxt;
      r_imp_idx    <= w_imp_nxt;
      r_per_idx    <= w_per_nxt;
      r_gate       <= (w_state_nxt == S_PULSE);
      r_start_calc <= (w_state_nxt == S_PULSE) && (r_state != S_PULSE);
      r_stop_calc  <= (r_state == S_PULSE) && (w_state_nxt != S_PULSE);
      r_busy       <= (w_state_nxt != S_IDLE);
      r_done       <= w_done_nxt;
      if (w_accept) begin
        r_cfg_err <= 1'b0;
      end else if (w_reject) begin
        r_cfg_err <= 1'b1;
      end else begin
        r_cfg_err <= r_cfg_err;
      end
    end
  end

  // Burst configuration captured on an accepted start.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_timp <= '0;
      r_num  <= '0;
      r_vob  <= 1'b0;
      r_len  <= '0;
    end else if (w_accept) begin
      r_timp <= T_IMPULSE;
      r_num  <= NUM_OF_IMP;
      r_vob  <= VOBULATION;
      r_len  <= TBL_LEN;
    end else begin
      r_timp <= r_timp;
      r_num  <= r_num;
      r_vob  <= r_vob;
      r_len  <= r_len;
    end
  end

  // Period table: written only while idle, deliberately not cleared by RESET.
  always_ff @(posedge CLK) begin
    if (TBL_WE && (r_state == S_IDLE)) begin
      r_tbl[TBL_ADDR] <= TBL_DATA;
    end
  end

  assign GATE            = r_gate;
  assign SIGN_START_CALC = r_start_calc;
  assign SIGN_STOP_CALC  = r_stop_calc;
  assign IMP_IDX         = r_imp_idx;
  assign PER_IDX         = r_per_idx;
  assign BUSY            = r_busy;
  assign DONE            = r_done;
  assign CFG_ERR         = r_cfg_err;

endmodule

// File: tb/tb_pulse_train_scheduler.sv
`timescale 1ns/1ps
module tb_pulse_train_scheduler;
  localparam int DEPTH = 4;
  localparam int IMP_W = 10;
  localparam int PER_W = 13;
  localparam int CNT_W = 5;
  localparam int TPU   = 2;
  localparam int AW    = 2;
  localparam int ELEN  = 256;

  logic             CLK = 1'b0;
  logic             RESET, TBL_WE, VOBULATION, SIGN_START_GEN, ABORT, OUT_REG_READY;
  logic [AW-1:0]    TBL_ADDR;
  logic [PER_W-1:0] TBL_DATA;
  logic [AW:0]      TBL_LEN;
  logic [IMP_W-1:0] T_IMPULSE;
  logic [CNT_W-1:0] NUM_OF_IMP;
  logic             GATE, SIGN_START_CALC, SIGN_STOP_CALC, BUSY, DONE, CFG_ERR;
  logic [CNT_W-1:0] IMP_IDX;
  logic [AW-1:0]    PER_IDX;

  always #5 CLK = ~CLK;

  pulse_train_scheduler #(
    .DEPTH(DEPTH), .IMP_W(IMP_W), .PER_W(PER_W), .CNT_W(CNT_W), .TICKS_PER_UNIT(TPU)
  ) dut (
    .CLK(CLK), .RESET(RESET), .TBL_WE(TBL_WE), .TBL_ADDR(TBL_ADDR), .TBL_DATA(TBL_DATA),
    .TBL_LEN(TBL_LEN), .T_IMPULSE(T_IMPULSE), .NUM_OF_IMP(NUM_OF_IMP),
    .VOBULATION(VOBULATION), .SIGN_START_GEN(SIGN_START_GEN), .ABORT(ABORT),
    .OUT_REG_READY(OUT_REG_READY), .GATE(GATE), .SIGN_START_CALC(SIGN_START_CALC),
    .SIGN_STOP_CALC(SIGN_STOP_CALC), .IMP_IDX(IMP_IDX), .PER_IDX(PER_IDX), .BUSY(BUSY),
    .DONE(DONE), .CFG_ERR(CFG_ERR)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int m_tbl [DEPTH];
  int no_stall [8] = '{default: 0};

  typedef struct {
    int tb0, tb1, tb2, tb3;
    int timp, n, vob, len, stall_rel, stall_len;
    int r1, r2, r3, r4, done, err, width;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tbl_write(input int a, input int d);
    @(negedge CLK);
    TBL_WE   = 1'b1;
    TBL_ADDR = AW'(a);
    TBL_DATA = PER_W'(d);
    m_tbl[a] = d;
    @(negedge CLK);
    TBL_WE   = 1'b0;
  endtask

  task automatic set_cfg(input int timp, input int n, input int vob, input int len);
    T_IMPULSE  = IMP_W'(timp);
    NUM_OF_IMP = CNT_W'(n);
    VOBULATION = (vob != 0);
    TBL_LEN    = (AW+1)'(len);
  endtask

  // Reference model: builds the expected waveform of one burst from its
  // impulse schedule (rise time, period, stall per boundary), then drives
  // the DUT and compares cycle by cycle. r = 0 is the cycle START is driven.
  task automatic run_model(input string tag, input int n, input int timp, input int vob,
                           input int len, input int stalls [8], input bit disturb);
    bit e_g [ELEN], e_sc [ELEN], e_sp [ELEN], e_dn [ELEN], e_bz [ELEN], e_rdy [ELEN];
    int e_imp [ELEN], e_per [ELEN];
    int t, pi, npi, p, b, e_end;
    for (int r = 0; r < ELEN; r++) begin
      e_g[r] = 0; e_sc[r] = 0; e_sp[r] = 0; e_dn[r] = 0; e_bz[r] = 0;
      e_rdy[r] = 1; e_imp[r] = 0; e_per[r] = 0;
    end
    for (int s = 0; s < stalls[0]; s++) e_rdy[s] = 0;
    t = 1 + stalls[0];
    e_end = 0;
    for (int k = 0; k < n; k++) begin
      pi = (vob != 0) ? (k % len) : 0;
      p  = m_tbl[pi];
      for (int c = t; c < t + p * TPU; c++) begin
        e_imp[c] = k; e_per[c] = pi; e_g[c] = (c < t + timp * TPU);
      end
      e_sc[t] = 1;
      e_sp[t + timp * TPU] = 1;
      if (k == n - 1) begin
        e_dn[t + p * TPU - 1] = 1;
        e_end = t + p * TPU;
      end else begin
        b   = t + p * TPU - 1;
        npi = (vob != 0) ? ((k + 1) % len) : 0;
        for (int s = 0; s < stalls[k + 1]; s++) begin
          e_rdy[b + s] = 0;
          e_imp[b + 1 + s] = k + 1;
          e_per[b + 1 + s] = npi;
        end
        t = t + p * TPU + stalls[k + 1];
      end
    end
    for (int r = 1; r < e_end; r++) e_bz[r] = 1;
    set_cfg(timp, n, vob, len);
    for (int r = 0; r < e_end + 3; r++) begin
      @(negedge CLK);
      chk($sformatf("%s ctl{gate,start,stop,done,busy} r=%0d", tag, r),
          int'({GATE, SIGN_START_CALC, SIGN_STOP_CALC, DONE, BUSY}),
          int'({e_g[r], e_sc[r], e_sp[r], e_dn[r], e_bz[r]}));
      if (e_bz[r]) begin
        chk($sformatf("%s imp_idx r=%0d", tag, r), int'(IMP_IDX), e_imp[r]);
        chk($sformatf("%s per_idx r=%0d", tag, r), int'(PER_IDX), e_per[r]);
      end
      SIGN_START_GEN = (r == 0) || (disturb && r == 5);
      OUT_REG_READY  = e_rdy[r];
      TBL_WE         = disturb && (r == 5);
      if (disturb && r == 5) begin
        TBL_ADDR = '0; TBL_DATA = PER_W'(3);
        set_cfg(1, 1, (vob != 0) ? 0 : 1, 1);
      end
    end
    TBL_WE = 1'b0; SIGN_START_GEN = 1'b0; OUT_REG_READY = 1'b1;
  endtask

  initial begin
    int rise [4], fall0, done_r, err_s, busy_s, nr, nd, gcnt;
    bit prev;
    int st [8];

    RESET = 1'b1; TBL_WE = 1'b0; TBL_ADDR = '0; TBL_DATA = '0;
    SIGN_START_GEN = 1'b0; ABORT = 1'b0; OUT_REG_READY = 1'b1;
    set_cfg(1, 1, 0, 1);

    vecs[0]  = '{5,9,9,9, 2,3,0,1, -1,0,  1,11,21,-1, 30,0,4};
    vecs[1]  = '{4,6,8,9, 1,4,1,3, -1,0,  1, 9,21,37, 44,0,2};
    vecs[2]  = '{5,9,9,9, 2,3,0,1, 10,7,  1,18,28,-1, 37,0,4};
    vecs[3]  = '{5,9,9,9, 5,3,0,1, -1,0, -1,-1,-1,-1, -1,1,0};
    vecs[4]  = '{5,9,9,9, 4,1,0,1, -1,0,  1,-1,-1,-1, 10,0,8};
    vecs[5]  = '{5,9,9,9, 1,1,0,0, -1,0, -1,-1,-1,-1, -1,1,0};
    vecs[6]  = '{5,9,9,9, 1,1,0,5, -1,0, -1,-1,-1,-1, -1,1,0};
    vecs[7]  = '{5,9,9,9, 0,1,0,1, -1,0, -1,-1,-1,-1, -1,1,0};
    vecs[8]  = '{8,8,3,8, 4,1,1,3, -1,0, -1,-1,-1,-1, -1,1,0};
    vecs[9]  = '{8,8,3,8, 4,2,0,3, -1,0,  1,17,-1,-1, 32,0,8};
    vecs[10] = '{8,6,3,8, 4,3,1,2, -1,0,  1,17,29,-1, 44,0,8};
    vecs[11] = '{3,4,5,6, 2,4,1,4, -1,0,  1, 7,15,25, 36,0,4};

    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("reset outputs", int'({GATE, SIGN_START_CALC, SIGN_STOP_CALC, IMP_IDX, PER_IDX,
                               BUSY, DONE, CFG_ERR}), 0);

    // Table-driven bursts: rising edges, first pulse width, DONE cycle, CFG_ERR.
    for (int v = 0; v < 12; v++) begin
      tbl_write(0, vecs[v].tb0); tbl_write(1, vecs[v].tb1);
      tbl_write(2, vecs[v].tb2); tbl_write(3, vecs[v].tb3);
      set_cfg(vecs[v].timp, vecs[v].n, vecs[v].vob, vecs[v].len);
      for (int i = 0; i < 4; i++) rise[i] = -1;
      fall0 = -1; done_r = -1; err_s = -1; busy_s = -1; nr = 0; prev = 1'b0;
      for (int r = 0; r < 60; r++) begin
        @(negedge CLK);
        if (GATE && !prev) begin
          if (nr < 4) rise[nr] = r;
          nr++;
        end
        if (!GATE && prev && fall0 < 0) fall0 = r;
        if (DONE) done_r = r;
        if (r == 2) begin err_s = int'(CFG_ERR); busy_s = int'(BUSY); end
        prev = GATE;
        SIGN_START_GEN = (r == 0);
        OUT_REG_READY  = !(vecs[v].stall_rel >= 0 && r >= vecs[v].stall_rel &&
                           r < vecs[v].stall_rel + vecs[v].stall_len);
      end
      chk($sformatf("vec%0d rise1", v), rise[0], vecs[v].r1);
      chk($sformatf("vec%0d rise2", v), rise[1], vecs[v].r2);
      chk($sformatf("vec%0d rise3", v), rise[2], vecs[v].r3);
      chk($sformatf("vec%0d rise4", v), rise[3], vecs[v].r4);
      chk($sformatf("vec%0d done", v), done_r, vecs[v].done);
      chk($sformatf("vec%0d cfg_err", v), err_s, vecs[v].err);
      chk($sformatf("vec%0d busy", v), busy_s, (vecs[v].err != 0) ? 0 : 1);
      chk($sformatf("vec%0d width", v), fall0 - rise[0], vecs[v].width);
    end

    // Abort on the third GATE cycle, then a normal burst.
    tbl_write(0, 5);
    set_cfg(2, 3, 0, 1);
    nd = 0; gcnt = 0;
    for (int r = 0; r < 40; r++) begin
      @(negedge CLK);
      if (r == 3) chk("abort gate before", int'(GATE), 1);
      if (r == 4) chk("abort ctl{gate,stop,busy,done}",
                      int'({GATE, SIGN_STOP_CALC, BUSY, DONE}), 4'b0100);
      if (r >= 4 && DONE) nd++;
      if (r >= 4 && GATE) gcnt++;
      SIGN_START_GEN = (r == 0);
      ABORT          = (r == 3);
    end
    chk("abort no done", nd, 0);
    chk("abort gate stays low", gcnt, 0);
    run_model("after_abort", 3, 2, 0, 1, no_stall, 1'b0);

    // START and table write during a burst, then a burst proving the table kept 5.
    run_model("busy_disturb", 3, 2, 0, 1, no_stall, 1'b1);
    run_model("tbl_kept", 2, 2, 0, 1, no_stall, 1'b0);

    // START and ABORT together in IDLE.
    set_cfg(2, 3, 0, 1);
    @(negedge CLK);
    SIGN_START_GEN = 1'b1; ABORT = 1'b1;
    @(negedge CLK);
    SIGN_START_GEN = 1'b0; ABORT = 1'b0;
    chk("start+abort busy", int'({BUSY, GATE}), 0);
    repeat (3) @(negedge CLK);
    chk("start+abort busy later", int'(BUSY), 0);

    // RESET during GAP.
    for (int r = 0; r < 9; r++) begin
      @(negedge CLK);
      if (r == 6) chk("rst busy before", int'(BUSY), 1);
      if (r == 7) chk("rst outputs", int'({GATE, SIGN_START_CALC, SIGN_STOP_CALC, IMP_IDX,
                                           PER_IDX, BUSY, DONE, CFG_ERR}), 0);
      SIGN_START_GEN = (r == 0);
      RESET          = (r == 6);
    end
    RESET = 1'b0;

`ifdef SCHED_CONTINUOUS_EN
    tbl_write(0, 3);
    set_cfg(1, 0, 0, 1);
    nr = 0; nd = 0; prev = 1'b0;
    for (int r = 0; r < 246; r++) begin
      @(negedge CLK);
      if (GATE && !prev) begin
        chk($sformatf("cont imp_idx #%0d", nr), int'(IMP_IDX), nr % 32);
        nr++;
      end
      if (DONE) nd++;
      if (r == 239) chk("cont abort busy", int'(BUSY), 0);
      prev = GATE;
      SIGN_START_GEN = (r == 0);
      ABORT          = (r == 238);
    end
    ABORT = 1'b0;
    chk("cont rises", nr, 40);
    chk("cont no done", nd, 0);
`else
    set_cfg(1, 0, 0, 1);
    @(negedge CLK);
    SIGN_START_GEN = 1'b1;
    @(negedge CLK);
    SIGN_START_GEN = 1'b0;
    chk("num0 cfg_err", int'(CFG_ERR), 1);
    chk("num0 busy", int'(BUSY), 0);
`endif

    // Randomized bursts against the reference model.
    for (int it = 0; it < 20; it++) begin
      int timp, len, n, vob;
      timp = int'($urandom_range(1, 3));
      len  = int'($urandom_range(1, 4));
      n    = int'($urandom_range(1, 5));
      vob  = int'($urandom_range(0, 1));
      for (int a = 0; a < DEPTH; a++) tbl_write(a, timp + int'($urandom_range(1, 4)));
      for (int k = 0; k < 8; k++)
        st[k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_model($sformatf("rnd%0d", it), n, timp, vob, len, st, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
